// File: rtl/ibex_rvfi_trace_buffer.sv
// Retirement trace capture buffer: records RVFI retire records into a circular FIFO,
// with optional PC trigger, post-trigger stop count and drop-new / overwrite-oldest full policy.
module ibex_rvfi_trace_buffer #(
   parameter int Depth    = 16,
   parameter int CntWidth = 16,
   parameter int LvlWidth = $clog2(Depth) + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rvfi_valid,
   input  logic [31:0]         rvfi_pc_rdata,
   input  logic [31:0]         rvfi_insn,
   input  logic [4:0]          rvfi_rd_addr,
   input  logic [31:0]         rvfi_rd_wdata,
   input  logic                rvfi_trap,
   input  logic                rvfi_intr,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic                trig_en_i,
   input  logic [31:0]         trig_pc_i,
   input  logic                wrap_mode_i,
   input  logic [CntWidth-1:0] post_count_i,
   output logic                rec_valid_o,
   input  logic                rec_ready_i,
   output logic [31:0]         rec_pc_o,
   output logic [31:0]         rec_insn_o,
   output logic [31:0]         rec_rd_wdata_o,
   output logic [4:0]          rec_rd_addr_o,
   output logic                rec_trap_o,
   output logic                rec_intr_o,
   output logic [LvlWidth-1:0] level_o,
   output logic [CntWidth-1:0] drop_cnt_o,
   output logic [1:0]          state_o
);

   localparam int PtrW = $clog2(Depth);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e state, state_nxt;

   logic [PtrW-1:0]     rptr, wptr;
   logic [LvlWidth-1:0] level;
   logic [CntWidth-1:0] cnt, drop_cnt, cnt_next;

   logic [31:0] pc_mem    [Depth];
   logic [31:0] insn_mem  [Depth];
   logic [31:0] wdata_mem [Depth];
   logic [4:0]  rd_mem    [Depth];
   logic        trap_mem  [Depth];
   logic        intr_mem  [Depth];

   logic trig_hit, full, pop, push_req, arm, drop, overwrite, write, last;

   assign trig_hit  = rvfi_valid && (rvfi_pc_rdata == trig_pc_i);
   assign full      = (level == LvlWidth'(Depth));
   assign pop       = rec_valid_o && rec_ready_i;
   assign drop      = push_req && full && !pop;
   assign overwrite = drop && wrap_mode_i;
   // write covers both accepted and overwriting pushes; only drop-new discards
   assign write     = push_req && !(drop && !wrap_mode_i);
   assign cnt_next  = cnt + 1'b1;
   assign last      = write && (post_count_i != '0) && (cnt_next == post_count_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (stop_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (start_i) state_nxt = trig_en_i ? ARMED : CAPTURE;
            ARMED:      if (!trig_en_i || trig_hit) state_nxt = CAPTURE;
            default:    state_nxt = state;
         endcase
         if (last) state_nxt = DONE;
      end
   end

   always_comb begin
      state_o  = state;
      push_req = rvfi_valid && !stop_i &&
                 ((state == CAPTURE) || ((state == ARMED) && trig_en_i && trig_hit));
      arm      = start_i && !stop_i && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rptr     <= '0;
         wptr     <= '0;
         level    <= '0;
         cnt      <= '0;
         drop_cnt <= '0;
      end else begin
         if (write)             wptr <= wptr + 1'b1;
         if (pop || overwrite)  rptr <= rptr + 1'b1;
         if (write && !overwrite && !pop)       level <= level + 1'b1;
         else if (!(write && !overwrite) && pop) level <= level - 1'b1;
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
         if (arm)        cnt <= '0;
         else if (write) cnt <= cnt_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (write) begin
         pc_mem[wptr]    <= rvfi_pc_rdata;
         insn_mem[wptr]  <= rvfi_insn;
         wdata_mem[wptr] <= rvfi_rd_wdata;
         rd_mem[wptr]    <= rvfi_rd_addr;
         trap_mem[wptr]  <= rvfi_trap;
         intr_mem[wptr]  <= rvfi_intr;
      end
   end

   assign rec_valid_o    = (level != '0);
   assign rec_pc_o       = pc_mem[rptr];
   assign rec_insn_o     = insn_mem[rptr];
   assign rec_rd_wdata_o = wdata_mem[rptr];
   assign rec_rd_addr_o  = rd_mem[rptr];
   assign rec_trap_o     = trap_mem[rptr];
   assign rec_intr_o     = intr_mem[rptr];
   assign level_o        = level;
   assign drop_cnt_o     = drop_cnt;

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
Name: ibex_rvfi_trace_buffer

Overview:
Parametrised on-chip retirement trace capture buffer. It sits beside the core's RVFI port in the tracing top level and records retired-instruction records into a circular FIFO. Capture can start immediately or on a PC trigger, and can stop after a post-trigger count. Records are drained over a valid/ready stream. Buffer-full handling is selectable: drop newest, or overwrite oldest.

Parameters:
Depth, 16, number of record entries; power of two, >= 2.
CntWidth, 16, width of post_count_i and drop_cnt_o.
LvlWidth, $clog2(Depth)+1, width of level_o (derived; do not override).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
rvfi_valid  in  1  retirement strobe
rvfi_pc_rdata  in  32  PC of retired instruction
rvfi_insn  in  32  instruction word
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  destination write data
rvfi_trap  in  1  instruction trapped
rvfi_intr  in  1  first instruction of a trap handler
start_i  in  1  pulse: leave IDLE/DONE, go ARMED
stop_i  in  1  pulse: abort capture, go IDLE
trig_en_i  in  1  1 = wait for PC match; 0 = capture from next retire
trig_pc_i  in  32  trigger PC
wrap_mode_i  in  1  0 = drop-new when full; 1 = overwrite oldest
post_count_i  in  CntWidth  records to capture before DONE; 0 = unlimited
rec_valid_o  out  1  head record available
rec_ready_i  in  1  consumer accepts head record
rec_pc_o / rec_insn_o / rec_rd_wdata_o  out  32 each  head record fields
rec_rd_addr_o  out  5  head record field
rec_trap_o / rec_intr_o  out  1 each  head record fields
level_o  out  LvlWidth  entries held (0..Depth)
drop_cnt_o  out  CntWidth  dropped or overwritten records, saturating
state_o  out  2  FSM state: IDLE=0, ARMED=1, CAPTURE=2, DONE=3

Behaviour:
- Reset is synchronous. Values after reset:
  - FSM in IDLE; read pointer, write pointer and level all 0.
  - drop_cnt_o = 0, rec_valid_o = 0, captured-record counter = 0.
  - Record storage is not reset; rec_*_o fields are don't-care while rec_valid_o = 0.
- Push condition: a retire (rvfi_valid = 1) is pushed only in CAPTURE, or in ARMED on the matching cycle.
  - The trigger instruction itself is captured.
- FSM transitions:
  - IDLE/DONE -> ARMED on start_i. On this transition the record counter clears; drop_cnt_o is held.
  - ARMED -> CAPTURE when trig_en_i = 0, on the start edge itself, so the first retire after start is captured.
  - ARMED -> CAPTURE when trig_en_i = 1 and rvfi_valid && rvfi_pc_rdata == trig_pc_i.
  - CAPTURE -> DONE on the push that brings the record counter to post_count_i, when post_count_i != 0. The counter counts accepted and overwriting pushes; dropped pushes do not count.
  - Any state -> IDLE on stop_i. stop_i has priority over start_i and over a same-cycle push, which is discarded.
- Buffer contents are retained in DONE and IDLE and stay drainable there.
- Timing:
  - Write-to-visible latency is 1 cycle: a record pushed at edge N drives rec_valid_o from edge N.
  - rec_valid_o = (level != 0); head fields are a combinational read at the read pointer.
  - Pop = rec_valid_o && rec_ready_i.
- Full handling (level == Depth):
  - Push together with a pop in the same cycle: normal push + pop, level unchanged, no drop.
  - Push without a pop, wrap_mode_i = 0: record discarded, drop_cnt_o += 1.
  - Push without a pop, wrap_mode_i = 1: oldest entry overwritten, read pointer advances, level stays Depth, drop_cnt_o += 1.
- Empty buffer with a push: no pop is possible that cycle, and level becomes 1.
- Pointers wrap modulo Depth.
- drop_cnt_o saturates at all-ones and does not wrap.
- wrap_mode_i is sampled every cycle, so a mid-capture change takes effect immediately.

Test Plan:
1. Depth=16, trig_en_i=0, post_count_i=0, rec_ready_i=1. Pulse start_i, then 5 retires at PC 0x100, 0x104, ... -> 5 records drained in order one cycle after each push; level_o ends at 0; drop_cnt_o=0.
2. trig_en_i=1, trig_pc_i=0x200. Retire PCs 0x1F8, 0x1FC, 0x200, 0x204 -> only 0x200 and 0x204 captured; state_o goes 1 -> 2 on the 0x200 cycle.
3. wrap_mode_i=0, rec_ready_i=0, 20 retires -> level_o=16, drop_cnt_o=4; then drain -> the first 16 PCs come out.
4. wrap_mode_i=1, same stimulus as scenario 3 -> level_o=16, drop_cnt_o=4; drain yields retires 5..20.
5. post_count_i=3 with continuous retires -> exactly 3 records; state_o=3 after the 3rd push; further retires are ignored and drop_cnt_o is unchanged.
6. Full buffer with a simultaneous push and pop -> no drop, level_o stays 16. Then stop_i together with start_i and a retire -> state_o=0 and the retire is not pushed. Reset mid-capture -> level_o=0, rec_valid_o=0 next cycle.
